// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package addsub_pkg;

  // Operation select encoding for the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Legal geometry: SLICE nonzero, WIDTH a whole number (>= 1) of slices.
  function automatic bit width_ok(int unsigned width, int unsigned slice);
    return (slice != 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple adder built from full_adder cells.
// cmsb is the carry into the slice MSB, used for signed overflow.
module addsub_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  // Each bit keeps its own carry nets so the chain is not one looping vector.
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (ci),
      .s    (s[i]),
      .cout (co)
    );
  end

  assign cout = g_bit[SLICE-1].co;
  assign cmsb = g_bit[SLICE-1].ci;

endmodule

// File: rtl/full_adder.sv
// Structural 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g;
  logic pc;

  xor u_xp (p, a, b);
  xor u_xs (s, p, cin);
  and u_ag (g, a, b);
  and u_ap (pc, p, cin);
  or  u_oc (cout, g, pc);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one SLICE-bit ripple segment per stage,
// valid/ready on both sides with a single global stall enable.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSTAGE = WIDTH / SLICE;
  localparam int unsigned LAST   = NSTAGE - 1;
  // Inter-stage register count; kept at 1 so NSTAGE=1 still declares legal arrays.
  localparam int unsigned NREG   = (NSTAGE > 1) ? NSTAGE - 1 : 1;

  if (!width_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $fatal(1, "pipelined_addsub: WIDTH must be a nonzero multiple of SLICE");
  end

  logic             en;
  logic [WIDTH-1:0] beff;
  logic             cin0;

  // Stage inputs: stage 0 from the ports, stage k from register k-1.
  logic             in_v [NSTAGE];
  logic [WIDTH-1:0] in_a [NSTAGE];
  logic [WIDTH-1:0] in_b [NSTAGE];
  logic [WIDTH-1:0] in_s [NSTAGE];
  logic             in_c [NSTAGE];

  // Per-stage slice adder results and next sum word.
  logic [SLICE-1:0] sl_s [NSTAGE];
  logic             sl_c [NSTAGE];
  logic             sl_m [NSTAGE];
  logic [WIDTH-1:0] nxt_s [NSTAGE];

  // Inter-stage registers.
  logic             v_q [NREG];
  logic [WIDTH-1:0] a_q [NREG];
  logic [WIDTH-1:0] b_q [NREG];
  logic [WIDTH-1:0] s_q [NREG];
  logic             c_q [NREG];

  // Output registers.
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             zero_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign beff     = (sub == OP_SUB) ? ~b : b;
  assign cin0     = sub ^ carryin;

  // Route each stage's operands, partial sum and carry.
  always_comb begin
    in_v[0] = in_valid;
    in_a[0] = a;
    in_b[0] = beff;
    in_s[0] = '0;
    in_c[0] = cin0;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      in_v[k] = v_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = s_q[k-1];
      in_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    addsub_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a    (in_a[k][k*SLICE +: SLICE]),
      .b    (in_b[k][k*SLICE +: SLICE]),
      .cin  (in_c[k]),
      .s    (sl_s[k]),
      .cout (sl_c[k]),
      .cmsb (sl_m[k])
    );
  end

  // Splice each stage's slice result into the partial sum travelling with the beat.
  always_comb begin
    for (int k = 0; k < int'(NSTAGE); k++) begin
      nxt_s[k] = in_s[k];
      nxt_s[k][k*SLICE +: SLICE] = sl_s[k];
    end
  end

  // Inter-stage pipeline registers; everything holds when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NREG); k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < int'(NSTAGE) - 1; k++) begin
        v_q[k] <= in_v[k];
        a_q[k] <= in_a[k];
        b_q[k] <= in_b[k];
        s_q[k] <= nxt_s[k];
        c_q[k] <= sl_c[k];
      end
    end
  end

  // Final stage: register result and flags together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= in_v[LAST];
      sum_q       <= nxt_s[LAST];
      carryout_q  <= sl_c[LAST];
      overflow_q  <= sl_c[LAST] ^ sl_m[LAST];
      zero_q      <= (nxt_s[LAST] == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
